// File: rtl/uart_rx_fifo_pkg.sv
// Shared definitions for the UART receive path: FSM states, parity codes, baud divider.
// Pure declarations, no logic.
package uart_rx_fifo_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP,
    ST_BRK
  } rx_state_e;

  localparam int PAR_NONE = 0;
  localparam int PAR_ODD  = 1;
  localparam int PAR_EVEN = 2;

  // Rounded clocks-per-bit
  function automatic int calc_div(input int clk_hz, input int baud);
    return (clk_hz + baud / 2) / baud;
  endfunction

endpackage

// File: rtl/uart_rx_fifo_sync_fifo.sv
// Generic first-word-fall-through FIFO; head visible the cycle after the write, reads ignored when empty.
// A write into a full FIFO is only accepted when a read happens in the same cycle.
module sync_fifo #(
  parameter int W = 8,
  parameter int D = 16
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   wr_en,
  input  logic [W-1:0]           wr_data,
  input  logic                   rd_en,
  output logic [W-1:0]           rd_data,
  output logic                   empty,
  output logic                   full,
  output logic [$clog2(D+1)-1:0] count
);

  localparam int AW = $clog2(D);
  localparam int CW = $clog2(D + 1);

  logic [W-1:0]  mem_q [D];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q;
  logic          do_rd, do_wr;

  assign do_rd = rd_en && (count_q != '0);
  assign do_wr = wr_en && ((count_q != CW'(D)) || do_rd);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_wr) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_rd) rd_ptr_q <= rd_ptr_q + AW'(1);
      if (do_wr && !do_rd)      count_q <= count_q + CW'(1);
      else if (do_rd && !do_wr) count_q <= count_q - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr) mem_q[wr_ptr_q] <= wr_data;
  end

  // Head is forced to zero while empty so stale storage never leaks out
  assign rd_data = (count_q == '0) ? '0 : mem_q[rd_ptr_q];
  assign empty   = (count_q == '0);
  assign full    = (count_q == CW'(D));
  assign count   = count_q;

endmodule

// File: rtl/uart_rx_fifo.sv
// Oversampling UART receiver feeding an FWFT FIFO; word and error pulses appear 1 cycle after the stop-bit sample.
// No backpressure on the line: a word completing while the FIFO is full is dropped and flagged as overrun.
module uart_rx_fifo
  import uart_rx_fifo_pkg::*;
#(
  parameter int C_CLK_HZ     = 25000000,
  parameter int C_BAUD       = 115200,
  parameter int C_DATA_BITS  = 8,
  parameter int C_PARITY     = 0,
  parameter int C_STOP_BITS  = 1,
  parameter int C_FIFO_DEPTH = 16
) (
  input  logic                              clk,
  input  logic                              rstn,
  input  logic                              rxd,
  input  logic                              rd_en,
  output logic [C_DATA_BITS-1:0]            rd_data,
  output logic                              empty,
  output logic                              full,
  output logic [$clog2(C_FIFO_DEPTH+1)-1:0] count,
  output logic                              frame_err,
  output logic                              parity_err,
  output logic                              overrun,
  output logic                              break_det
);

  localparam int DIV  = calc_div(C_CLK_HZ, C_BAUD);
  localparam int CNTW = $clog2(DIV + 1);
  localparam int BITW = $clog2(C_DATA_BITS + 1);

  logic                   rx_meta_q, rxs_q, rxs_prev_q;
  rx_state_e              state_q, state_d;
  logic [CNTW-1:0]        cnt_q, cnt_d;
  logic [BITW-1:0]        bit_q, bit_d;
  logic [C_DATA_BITS-1:0] sh_q, sh_d;
  logic                   par_q, par_d;
  logic                   par_bad_q, par_bad_d;
  logic                   frame_err_q, frame_err_d;
  logic                   parity_err_q, parity_err_d;
  logic                   overrun_q, overrun_d;
  logic                   break_q, break_d;
  logic                   tick, fell, push, exp_par;

  assign tick    = (cnt_q == '0);
  assign fell    = rxs_prev_q & ~rxs_q;
  assign exp_par = (C_PARITY == PAR_ODD) ? ~par_q : par_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rx_meta_q  <= 1'b1;
      rxs_q      <= 1'b1;
      rxs_prev_q <= 1'b1;
    end else begin
      rx_meta_q  <= rxd;
      rxs_q      <= rx_meta_q;
      rxs_prev_q <= rxs_q;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:   if (fell) state_d = ST_START;
      ST_START:  if (tick) state_d = rxs_q ? ST_IDLE : ST_DATA;
      ST_DATA:   if (tick && bit_q == BITW'(C_DATA_BITS - 1))
                   state_d = (C_PARITY != PAR_NONE) ? ST_PARITY : ST_STOP;
      ST_PARITY: if (tick) state_d = ST_STOP;
      // Return at mid-stop so a back-to-back start edge is not missed
      ST_STOP:   if (tick) state_d = (!rxs_q && sh_q == '0) ? ST_BRK : ST_IDLE;
      ST_BRK:    if (rxs_q) state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    cnt_d        = (cnt_q != '0) ? cnt_q - CNTW'(1) : cnt_q;
    bit_d        = bit_q;
    sh_d         = sh_q;
    par_d        = par_q;
    par_bad_d    = par_bad_q;
    push         = 1'b0;
    frame_err_d  = 1'b0;
    parity_err_d = 1'b0;
    overrun_d    = 1'b0;
    break_d      = 1'b0;
    unique case (state_q)
      ST_IDLE:   if (fell) cnt_d = CNTW'(DIV / 2 - 1);
      ST_START:  if (tick) begin
                   cnt_d     = CNTW'(DIV - 1);
                   bit_d     = '0;
                   par_d     = 1'b0;
                   par_bad_d = 1'b0;
                 end
      ST_DATA:   if (tick) begin
                   cnt_d = CNTW'(DIV - 1);
                   sh_d  = {rxs_q, sh_q[C_DATA_BITS-1:1]};
                   par_d = par_q ^ rxs_q;
                   bit_d = bit_q + BITW'(1);
                 end
      ST_PARITY: if (tick) begin
                   cnt_d     = CNTW'(DIV - 1);
                   par_bad_d = (rxs_q != exp_par);
                 end
      ST_STOP:   if (tick) begin
                   push         = rxs_q;
                   parity_err_d = rxs_q & par_bad_q;
                   overrun_d    = rxs_q & full & ~rd_en;
                   frame_err_d  = ~rxs_q;
                   break_d      = ~rxs_q & (sh_q == '0);
                 end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt_q        <= '0;
      bit_q        <= '0;
      sh_q         <= '0;
      par_q        <= 1'b0;
      par_bad_q    <= 1'b0;
      frame_err_q  <= 1'b0;
      parity_err_q <= 1'b0;
      overrun_q    <= 1'b0;
      break_q      <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      bit_q        <= bit_d;
      sh_q         <= sh_d;
      par_q        <= par_d;
      par_bad_q    <= par_bad_d;
      frame_err_q  <= frame_err_d;
      parity_err_q <= parity_err_d;
      overrun_q    <= overrun_d;
      break_q      <= break_d;
    end
  end

  assign frame_err  = frame_err_q;
  assign parity_err = parity_err_q;
  assign overrun    = overrun_q;
  assign break_det  = break_q;

  sync_fifo #(
    .W (C_DATA_BITS),
    .D (C_FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rstn    (rstn),
    .wr_en   (push),
    .wr_data (sh_q),
    .rd_en   (rd_en),
    .rd_data (rd_data),
    .empty   (empty),
    .full    (full),
    .count   (count)
  );

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Three receivers (fast 8N1, fast 7E2 depth 4, default 115200 8N1) checked against a queue-based frame model.
module tb_uart_rx_fifo;

  localparam int DIV_F = 50;

  logic clk = 1'b0;
  always #20 clk = ~clk;

  logic       rstn;
  logic [2:0] rxd, rd_en, empty, full, frame_err, parity_err, overrun, break_det;
  logic [7:0] rd_data0, rd_data2;
  logic [6:0] rd_data1;
  logic [4:0] count0, count2;
  logic [2:0] count1;

  uart_rx_fifo #(.C_CLK_HZ(25000000), .C_BAUD(500000)) u_dut0 (
    .clk(clk), .rstn(rstn), .rxd(rxd[0]), .rd_en(rd_en[0]), .rd_data(rd_data0),
    .empty(empty[0]), .full(full[0]), .count(count0), .frame_err(frame_err[0]),
    .parity_err(parity_err[0]), .overrun(overrun[0]), .break_det(break_det[0]));

  uart_rx_fifo #(.C_CLK_HZ(25000000), .C_BAUD(500000), .C_DATA_BITS(7), .C_PARITY(2),
                 .C_STOP_BITS(2), .C_FIFO_DEPTH(4)) u_dut1 (
    .clk(clk), .rstn(rstn), .rxd(rxd[1]), .rd_en(rd_en[1]), .rd_data(rd_data1),
    .empty(empty[1]), .full(full[1]), .count(count1), .frame_err(frame_err[1]),
    .parity_err(parity_err[1]), .overrun(overrun[1]), .break_det(break_det[1]));

  uart_rx_fifo u_dut2 (
    .clk(clk), .rstn(rstn), .rxd(rxd[2]), .rd_en(rd_en[2]), .rd_data(rd_data2),
    .empty(empty[2]), .full(full[2]), .count(count2), .frame_err(frame_err[2]),
    .parity_err(parity_err[2]), .overrun(overrun[2]), .break_det(break_det[2]));

  int n_tests = 0;
  int n_fail  = 0;
  int obs_fe[3] = '{0, 0, 0}, obs_pe[3] = '{0, 0, 0}, obs_ov[3] = '{0, 0, 0}, obs_bk[3] = '{0, 0, 0};
  int exp_fe[3] = '{0, 0, 0}, exp_pe[3] = '{0, 0, 0}, exp_ov[3] = '{0, 0, 0}, exp_bk[3] = '{0, 0, 0};
  logic [8:0] q0[$], q1[$], q2[$];

  always @(negedge clk) begin
    for (int s = 0; s < 3; s++) begin
      if (frame_err[s]  === 1'b1) obs_fe[s]++;
      if (parity_err[s] === 1'b1) obs_pe[s]++;
      if (overrun[s]    === 1'b1) obs_ov[s]++;
      if (break_det[s]  === 1'b1) obs_bk[s]++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  function automatic int f_div(input int s);   return (s == 2) ? 217 : DIV_F; endfunction
  function automatic int f_nb(input int s);    return (s == 1) ? 7 : 8;       endfunction
  function automatic int f_par(input int s);   return (s == 1) ? 2 : 0;       endfunction
  function automatic int f_ns(input int s);    return (s == 1) ? 2 : 1;       endfunction
  function automatic int f_depth(input int s); return (s == 1) ? 4 : 16;      endfunction

  function automatic int q_size(input int s);
    case (s)
      0: return q0.size();
      1: return q1.size();
      default: return q2.size();
    endcase
  endfunction

  function automatic logic [8:0] q_front(input int s);
    case (s)
      0: return q0[0];
      1: return q1[0];
      default: return q2[0];
    endcase
  endfunction

  task automatic q_push(input int s, input logic [8:0] w);
    case (s)
      0: q0.push_back(w);
      1: q1.push_back(w);
      default: q2.push_back(w);
    endcase
  endtask

  task automatic q_popf(input int s);
    case (s)
      0: void'(q0.pop_front());
      1: void'(q1.pop_front());
      default: void'(q2.pop_front());
    endcase
  endtask

  function automatic logic [8:0] get_rdata(input int s);
    case (s)
      0: return {1'b0, rd_data0};
      1: return {2'b0, rd_data1};
      default: return {1'b0, rd_data2};
    endcase
  endfunction

  function automatic int get_count(input int s);
    case (s)
      0: return int'(count0);
      1: return int'(count1);
      default: return int'(count2);
    endcase
  endfunction

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Drives one frame; the parity bit is computed from the data, optionally inverted
  task automatic send(input int s, input logic [8:0] d, input bit bad_par, input bit stop_v, input int gap);
    logic pb;
    pb = 1'b0;
    rxd[s] = 1'b0;
    wait_cyc(f_div(s));
    for (int i = 0; i < f_nb(s); i++) begin
      rxd[s] = d[i];
      pb ^= d[i];
      wait_cyc(f_div(s));
    end
    if (f_par(s) != 0) begin
      if (f_par(s) == 1) pb = ~pb;
      if (bad_par) pb = ~pb;
      rxd[s] = pb;
      wait_cyc(f_div(s));
    end
    rxd[s] = stop_v;
    wait_cyc(f_div(s));
    rxd[s] = 1'b1;
    wait_cyc(f_div(s) * (f_ns(s) - 1 + gap));
  endtask

  task automatic model_frame(input int s, input logic [8:0] d, input bit bad_par, input bit stop_v);
    logic [8:0] w;
    w = d & 9'((1 << f_nb(s)) - 1);
    if (!stop_v) begin
      exp_fe[s]++;
      if (w == '0) exp_bk[s]++;
    end else begin
      if (bad_par && f_par(s) != 0) exp_pe[s]++;
      if (q_size(s) >= f_depth(s)) exp_ov[s]++;
      else q_push(s, w);
    end
  endtask

  task automatic check_status(input int s, input string tag);
    @(negedge clk);
    chk({tag, ":count"}, get_count(s), q_size(s));
    chk({tag, ":empty"}, empty[s], q_size(s) == 0);
    chk({tag, ":full"}, full[s], q_size(s) == f_depth(s));
    chk({tag, ":rd_data"}, get_rdata(s), (q_size(s) > 0) ? q_front(s) : 9'd0);
    chk({tag, ":frame_err"}, obs_fe[s], exp_fe[s]);
    chk({tag, ":parity_err"}, obs_pe[s], exp_pe[s]);
    chk({tag, ":overrun"}, obs_ov[s], exp_ov[s]);
    chk({tag, ":break_det"}, obs_bk[s], exp_bk[s]);
  endtask

  task automatic pop_chk(input int s, input string tag);
    @(negedge clk);
    chk({tag, ":pop_data"}, get_rdata(s), q_front(s));
    rd_en[s] = 1'b1;
    @(negedge clk);
    rd_en[s] = 1'b0;
    q_popf(s);
  endtask

  task automatic drain(input int s, input string tag);
    while (q_size(s) > 0) pop_chk(s, tag);
    check_status(s, {tag, "_drained"});
  endtask

  logic [8:0] d;
  int         lat;
  bit         found, sv;

  initial begin
    #8ms;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    rstn  = 1'b0;
    rxd   = '1;
    rd_en = '0;
    wait_cyc(3);
    for (int s = 0; s < 3; s++) check_status(s, "reset");
    rstn = 1'b1;
    wait_cyc(3);

    // Default 115200 baud: one 0x55 frame
    send(2, 9'h55, 1'b0, 1'b1, 1);
    model_frame(2, 9'h55, 1'b0, 1'b1);
    check_status(2, "t1");
    drain(2, "t1");

    // First-word latency from start edge, used later to land rd_en on the push cycle
    lat = 0;
    found = 1'b0;
    fork
      send(0, 9'h5A, 1'b0, 1'b1, 2);
      for (int k = 0; k < 3000 && !found; k++) begin
        @(negedge clk);
        lat++;
        if (empty[0] == 1'b0) found = 1'b1;
      end
    join
    model_frame(0, 9'h5A, 1'b0, 1'b1);
    chk("lat_found", found, 1);
    chk("lat_range", (lat >= 470 && lat <= 490), 1);
    check_status(0, "lat");
    drain(0, "lat");

    for (int i = 0; i < 20; i++) begin
      send(0, 9'(i), 1'b0, 1'b1, 0);
      model_frame(0, 9'(i), 1'b0, 1'b1);
    end
    wait_cyc(DIV_F);
    check_status(0, "t2");
    drain(0, "t2");

    for (int i = 0; i < 16; i++) begin
      d = 9'($urandom);
      send(0, d, 1'b0, 1'b1, 1);
      model_frame(0, d, 1'b0, 1'b1);
    end
    check_status(0, "t6_full");
    d = 9'($urandom);
    fork
      send(0, d, 1'b0, 1'b1, 1);
      begin
        wait_cyc(lat - 1);
        chk("t6:head", get_rdata(0), q_front(0));
        rd_en[0] = 1'b1;
        wait_cyc(1);
        rd_en[0] = 1'b0;
      end
    join
    q_popf(0);
    model_frame(0, d, 1'b0, 1'b1);
    check_status(0, "t6");
    drain(0, "t6");

    send(1, 9'h07, 1'b1, 1'b1, 1);
    model_frame(1, 9'h07, 1'b1, 1'b1);
    check_status(1, "t3");
    drain(1, "t3");
    for (int i = 0; i < 10; i++) begin
      d = 9'($urandom);
      sv = ($urandom_range(0, 2) == 0);
      send(1, d, sv, 1'b1, 1);
      model_frame(1, d, sv, 1'b1);
      check_status(1, "rnd1");
      if (q_size(1) > 0 && $urandom_range(0, 1) == 1) pop_chk(1, "rnd1");
    end
    drain(1, "rnd1");

    send(0, 9'hA5, 1'b0, 1'b0, 1);
    model_frame(0, 9'hA5, 1'b0, 1'b0);
    check_status(0, "t4_frame");
    rxd[0] = 1'b0;
    wait_cyc(20 * DIV_F);
    rxd[0] = 1'b1;
    wait_cyc(2 * DIV_F);
    model_frame(0, 9'h00, 1'b0, 1'b0);
    check_status(0, "t4_break");
    send(0, 9'h3C, 1'b0, 1'b1, 1);
    model_frame(0, 9'h3C, 1'b0, 1'b1);
    check_status(0, "t4_after");
    drain(0, "t4");

    // Short low glitch on an idle line must be rejected at the start-bit check
    rxd[0] = 1'b0;
    wait_cyc(7);
    rxd[0] = 1'b1;
    wait_cyc(3 * DIV_F);
    check_status(0, "t5_glitch");
    send(0, 9'h96, 1'b0, 1'b1, 1);
    model_frame(0, 9'h96, 1'b0, 1'b1);
    check_status(0, "t5_after_glitch");
    drain(0, "t5g");

    rxd[0] = 1'b0;
    wait_cyc(DIV_F);
    rxd[0] = 1'b1;
    wait_cyc(2 * DIV_F);
    rstn = 1'b0;
    wait_cyc(3);
    rstn = 1'b1;
    q0.delete();
    q1.delete();
    q2.delete();
    wait_cyc(8 * DIV_F);
    check_status(0, "t5_rst");
    send(0, 9'hC3, 1'b0, 1'b1, 1);
    model_frame(0, 9'hC3, 1'b0, 1'b1);
    check_status(0, "t5_after_rst");
    drain(0, "t5r");

    for (int i = 0; i < 16; i++) begin
      d = 9'($urandom);
      sv = ($urandom_range(0, 5) != 0);
      send(0, d, 1'b0, sv, sv ? $urandom_range(0, 2) : 1);
      model_frame(0, d, 1'b0, sv);
      check_status(0, "rnd0");
      if (q_size(0) > 0 && $urandom_range(0, 1) == 1) pop_chk(0, "rnd0");
    end
    drain(0, "rnd0");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
